// File: rtl/sr_latch_sequencer.sv
// Timed S/R/Enable pulse generator for a gated SR latch: every set/reset request
// becomes a setup -> enable pulse -> hold sequence that never presents S=R=1.
module sr_latch_sequencer #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Cmd_valid,
    input  logic [1:0] Cmd_op,
    output logic       Cmd_ready,
    output logic       S,
    output logic       R,
    output logic       Enable,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [7:0] Applied_count
);

    localparam int MAX_SP     = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_CYCLES = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    op_reg, op_next;
    logic          s_reg, s_next;
    logic          r_reg, r_next;
    logic          en_reg, en_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic [7:0]    count_reg, count_next;
    logic          accept;

    assign Cmd_ready     = (state_reg == IDLE);
    assign accept        = Cmd_valid && (state_reg == IDLE);
    assign S             = s_reg;
    assign R             = r_reg;
    assign Enable        = en_reg;
    assign Busy          = busy_reg;
    assign Done          = done_reg;
    assign Err           = err_reg;
    assign Applied_count = count_reg;

    // Outputs are computed one cycle ahead so that every latch drive is a flop.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        s_next     = 1'b0;
        r_next     = 1'b0;
        en_next    = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        count_next = count_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (Cmd_op)
                        2'b01, 2'b10: begin
                            op_next    = Cmd_op;
                            state_next = SETUP;
                            cnt_next   = SETUP_LOAD;
                            s_next     = Cmd_op[0];
                            r_next     = Cmd_op[1];
                            busy_next  = 1'b1;
                        end
                        2'b00:   done_next = 1'b1;
                        default: err_next  = 1'b1;
                    endcase
                end
            end
            SETUP: begin
                s_next    = op_reg[0];
                r_next    = op_reg[1];
                busy_next = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LOAD;
                    en_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            PULSE: begin
                s_next    = op_reg[0];
                r_next    = op_reg[1];
                busy_next = 1'b1;
                en_next   = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                    en_next    = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            HOLD: begin
                s_next    = op_reg[0];
                r_next    = op_reg[1];
                busy_next = 1'b1;
                if (cnt_reg == '0) begin
                    // S/R drop here, so back-to-back sequences always see one low cycle.
                    state_next = IDLE;
                    s_next     = 1'b0;
                    r_next     = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    count_next = count_reg + 8'd1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= 2'b00;
            s_reg     <= 1'b0;
            r_reg     <= 1'b0;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            s_reg     <= s_next;
            r_reg     <= r_next;
            en_reg    <= en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            count_reg <= count_next;
        end
    end

endmodule
